seq_chunk_adder: RTL

- Parametrised multi-cycle adder; next generation of the team's half/full adder cells.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, and propagates carry between chunks in a register.
- Valid/ready handshake on both sides.
- Used where a full-width single-cycle carry chain would fail timing: datapath accumulators, checksum units.

---
 rtl/adder_pkg.sv | 16 +
 rtl/chunk_add.sv | 26 ++
 rtl/seq_chunk_adder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked adder family: FSM encoding and a
// parameter-legality helper that sibling adders can reuse.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when the operand width splits into whole chunks of the given size.
  function automatic bit chunk_divides(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also
// exposes the carry into its top bit so callers can derive signed overflow.
module chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: captures a, b, cin, then adds CHUNK bits per clock with
// the inter-chunk carry held in a register; valid/ready on both sides.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || !chunk_divides(WIDTH, CHUNK)) begin : g_bad_params
    $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH (WIDTH=%0d CHUNK=%0d)",
           WIDTH, CHUNK);
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [CHUNK-1:0]  x_chunk, y_chunk, s_chunk;
  logic              co_chunk, msb_chunk;
  logic              last_chunk;

  // Select the operand slice addressed by the chunk index.
  always_comb begin
    x_chunk = '0;
    y_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        x_chunk = a_q[k*CHUNK +: CHUNK];
        y_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .x     (x_chunk),
    .y     (y_chunk),
    .ci    (carry_q),
    .s     (s_chunk),
    .co    (co_chunk),
    .c_msb (msb_chunk)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end

      BUSY: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_chunk;
          end
        end
        carry_d = co_chunk;
        idx_d   = idx_q + 1'b1;
        // Top chunk: its carry-out is the final cout and never wraps into bit 0.
        if (last_chunk) begin
          cout_d  = co_chunk;
          ovf_d   = msb_chunk ^ co_chunk;
          idx_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
